// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg
//   Shared types and constants for the RV32I immediate encoder:
//   format codes (EXT_*), the canonical NOP word, the shift funct3 codes
//   and the packed field bundle carried through pipeline stage A.
package imm_encoder_pkg;

  // Format codes, matching the decode-side sign-extender. Codes 6 and 7
  // are unassigned and are flagged as errors by the packer.
  typedef enum logic [2:0] {
    EXT_NONE = 3'd0,  // R-type, no immediate
    EXT_I    = 3'd1,
    EXT_S    = 3'd2,
    EXT_B    = 3'd3,
    EXT_U    = 3'd4,
    EXT_J    = 3'd5
  } ext_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0,x0,0

  // I-type funct3 values that select the shift-immediate layout.
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;  // srli / srai

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fields_t;

endpackage

// File: rtl/imm_pack.sv
// imm_pack
//   Purely combinational instruction packer and immediate range check.
//   Ports:
//     f     in   fields_t  format, opcode, funct3/7, registers, raw immediate
//     inst  out  32        packed instruction word (NOP when err)
//     err   out  1         immediate out of range or unknown format
import imm_encoder_pkg::*;

module imm_pack (
  input  fields_t     f,
  output logic [31:0] inst,
  output logic        err
);

  logic [31:0] word;
  logic        is_shift;

  assign is_shift = (f.funct3 == F3_SLLI) || (f.funct3 == F3_SRXI);

  // Range checks are done as "upper bits are a sign extension of the field
  // MSB", which is the exact condition for the value to fit the field.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    word = INST_NOP;
    err  = 1'b0;
    case (f.fmt)
      EXT_NONE: begin
        word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      end
      EXT_I: begin
        if (is_shift) begin
          word = {f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
          err  = |f.imm[31:5];
        end else begin
          word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
          err  = f.imm[31:11] != {21{f.imm[11]}};
        end
      end
      EXT_S: begin
        word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
        err  = f.imm[31:11] != {21{f.imm[11]}};
      end
      EXT_B: begin
        word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                f.imm[4:1], f.imm[11], f.opcode};
        err  = f.imm[0] || (f.imm[31:12] != {20{f.imm[12]}});
      end
      EXT_U: begin
        word = {f.imm[31:12], f.rd, f.opcode};
        err  = |f.imm[11:0];
      end
      EXT_J: begin
        word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                f.rd, f.opcode};
        err  = f.imm[0] || (f.imm[31:20] != {12{f.imm[20]}});
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

  assign inst = err ? INST_NOP : word;

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder
//   Two-stage pipeline that packs (format, fields, immediate) into RV32I
//   instruction words and streams them with a word address to the IROM
//   preload port. Stage A holds the raw fields; the packer runs on them and
//   stage B registers the packed word onto the outputs.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     clr                   sync pulse: zero out_addr and err_sticky
//     in_valid/in_ready     input handshake
//     fmt, opcode, funct3, funct7, rd, rs1, rs2, imm   request fields
//     out_valid/out_ready   output handshake
//     out_inst, out_err     packed word and its error flag
//     out_addr              word address of the current output
//     err_sticky            set once any error word has been emitted
import imm_encoder_pkg::*;

module imm_encoder #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic              out_err,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_sticky
);

  logic        a_valid;
  fields_t     a_fields;
  logic        en_a;
  logic        en_b;
  logic        out_fire;
  logic [31:0] pack_inst;
  logic        pack_err;

  // Each stage advances when the stage after it is empty or draining.
  assign en_b     = ~out_valid | out_ready;
  assign en_a     = ~a_valid | en_b;
  assign in_ready = en_a;
  assign out_fire = out_valid & out_ready;

  // Stage A: capture request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid  <= 1'b0;
      a_fields <= '0;
    end else if (en_a) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      a_valid <= in_valid;
      if (in_valid) begin
        a_fields <= '{fmt: fmt, opcode: opcode, funct3: funct3,
                      funct7: funct7, rd: rd, rs1: rs1, rs2: rs2, imm: imm};
      end
    end
  end

  imm_pack u_pack (
    .f    (a_fields),
    .inst (pack_inst),
    .err  (pack_err)
  );

  // Stage B: output register. Data only loads with a valid word, so the
  // outputs hold while stalled and after the last word drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
    end else if (en_b) begin
      out_valid <= a_valid;
      if (a_valid) begin
        out_inst <= pack_inst;
        out_err  <= pack_err;
      end
    end
  end

  // Address counter and sticky error; clr takes priority over a handshake
  // in the same cycle. The counter wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr   <= '0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      out_addr   <= '0;
      err_sticky <= 1'b0;
    end else if (out_fire) begin
      out_addr <= out_addr + 1'b1;
      if (out_err) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder
//   Directed bench for imm_encoder with a scoreboard: the expected word for
//   each request is pushed when the DUT accepts it and compared while the
//   word sits on the outputs. A second instance with ADDR_W=2 checks wrap.
import imm_encoder_pkg::*;

module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic        out_err;
  logic [11:0] out_addr;
  logic        err_sticky;

  logic        in_ready2, out_valid2, out_err2, err_sticky2;
  logic [31:0] out_inst2;
  logic [1:0]  out_addr2;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .out_addr(out_addr), .err_sticky(err_sticky)
  );

  imm_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready2), .fmt(fmt), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
    .out_err(out_err2), .out_addr(out_addr2), .err_sticky(err_sticky2)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_inst = '0;
  logic        exp_err = 1'b0;
  logic [11:0] addr_exp = '0;
  logic [1:0]  addr2_exp = '0;
  logic        sticky_exp = 1'b0;
  int          n_vec = 0;
  int          n_fail = 0;
  int          n_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic fire;
      logic fire_err;
      fire     = 1'b0;
      fire_err = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_word", {31'd0, out_valid}, 32'd0);
        end else begin
          check("out_inst", out_inst, sb[0].inst);
          check("out_err", {31'd0, out_err}, {31'd0, sb[0].err});
          check("out_addr", {20'd0, out_addr}, {20'd0, addr_exp});
          check("out_addr_w2", {30'd0, out_addr2}, {30'd0, addr2_exp});
          check("out_inst_w2", out_inst2, sb[0].inst);
          if (out_ready) begin
            fire     = 1'b1;
            fire_err = sb[0].err;
            void'(sb.pop_front());
          end
        end
      end
      check("err_sticky", {31'd0, err_sticky}, {31'd0, sticky_exp});
      if (clr) begin
        addr_exp   = '0;
        addr2_exp  = '0;
        sticky_exp = 1'b0;
      end else if (fire) begin
        addr_exp  = addr_exp + 12'd1;
        addr2_exp = addr2_exp + 2'd1;
        if (fire_err) sticky_exp = 1'b1;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{inst: exp_inst, err: exp_err});
        n_acc++;
      end
    end
  end

  task automatic set_word(input logic [2:0] f, input logic [6:0] op,
                          input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [31:0] im,
                          input logic [31:0] ei, input logic ee);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
    exp_inst = ei; exp_err = ee;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input string tag);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic [2:0] f,
                      input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic [31:0] ei,
                      input logic ee);
    set_word(f, op, f3, f7, d, s1, s2, im, ei, ee);
    wait_accept(tag);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drain"}, sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  initial begin
    int n0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_out_addr", {20'd0, out_addr}, 32'd0);
    check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // addi x1,x0,5 with two-cycle latency check
    set_word(EXT_I, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,
             32'h0050_0093, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    drain("addi");

    // Back-to-back stream
    send("sw", EXT_S, OP_ST, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,
         32'h0020_A423, 1'b0);
    send("beq", EXT_B, OP_BR, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4,
         32'hFE00_0EE3, 1'b0);
    send("lui", EXT_U, OP_LUI, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0,
         32'h1234_5000, 32'h1234_52B7, 1'b0);
    send("jal", EXT_J, OP_JAL, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,
         32'h0010_00EF, 1'b0);
    send("srai", EXT_I, OP_IMM, 3'b101, 7'b0100000, 5'd3, 5'd3, 5'd0,
         32'd4, 32'h4041_D193, 1'b0);
    send("add", EXT_NONE, OP_REG, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,
         32'h0020_81B3, 1'b0);
    send("addi_min", EXT_I, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0,
         -32'sd2048, 32'h8000_0093, 1'b0);
    send("jal_min", EXT_J, OP_JAL, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0,
         32'hFFF0_0000, 32'h8000_006F, 1'b0);
    drain("stream");

    // Error words
    send("b_odd", EXT_B, OP_BR, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3,
         INST_NOP, 1'b1);
    send("i_2048", EXT_I, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,
         INST_NOP, 1'b1);
    send("u_low", EXT_U, OP_LUI, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0,
         32'h0000_1001, INST_NOP, 1'b1);
    send("shamt32", EXT_I, OP_IMM, 3'b101, 7'd0, 5'd3, 5'd3, 5'd0, 32'd32,
         INST_NOP, 1'b1);
    send("bad_fmt", 3'd6, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0,
         INST_NOP, 1'b1);
    drain("errors");
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_err_sticky", {31'd0, err_sticky}, 32'd0);
    check("clr_out_addr", {20'd0, out_addr}, 32'd0);

    // Stall: two words fill the pipe, the third must wait
    out_ready = 1'b0;
    n0 = n_acc;
    send("stall_w1", EXT_I, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1,
         32'h0010_0093, 1'b0);
    send("stall_w2", EXT_I, OP_IMM, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2,
         32'h0020_0113, 1'b0);
    set_word(EXT_I, OP_IMM, 3'b000, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3,
             32'h0030_0193, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    check("stall_accepted", n_acc - n0, 32'd2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept("stall_w3");
    drain("stall");

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    send("rst_w1", EXT_I, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7,
         32'h0070_0093, 1'b0);
    send("rst_w2", EXT_I, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8,
         32'h0080_0093, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_addr", {20'd0, out_addr}, 32'd0);
    sb.delete();
    addr_exp   = '0;
    addr2_exp  = '0;
    sticky_exp = 1'b0;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    send("post_rst", EXT_I, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,
         32'h0050_0093, 1'b0);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-side immediate sign-extender. Takes a format code, register/function fields and a full 32-bit immediate, and packs them into a 32-bit RV32I instruction word.
- Range-checks the immediate for the chosen format.
- Streams encoded words with a word address to the IROM write/preload port (self-test and boot-patch path).
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- ADDR_W, 12, width of the output word-address counter; wraps at 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  sync pulse: zeroes out_addr and err_sticky; does not flush the pipeline
- in_valid  in  1  input request valid
- in_ready  out  1  input can be accepted this cycle
- fmt  in  3  format, using the `EXT_*` codes in defines.vh; `EXT_NONE` means R-type
- opcode  in  7  instruction [6:0]
- funct3  in  3  instruction [14:12]
- funct7  in  7  R-type [31:25]; also I-type shift [31:25]
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  signed byte-offset or value, unencoded
- out_valid  out  1  out_inst/out_addr/out_err valid
- out_ready  in  1  sink accepts
- out_inst  out  32  encoded instruction
- out_err  out  1  range/format error on this word
- out_addr  out  ADDR_W  word address of the current output
- err_sticky  out  1  set by any emitted error word

Behaviour:
- Reset values: out_valid=0, out_inst=0, out_err=0, out_addr=0, err_sticky=0, both stage valids=0.
  - Reset is asynchronous and takes effect mid-operation; in-flight words are discarded.
- Pipeline:
  - Stage A registers the fields and computes err.
  - Stage B registers the packed word and drives the outputs.
- Handshake:
  - en_B = ~out_valid | out_ready
  - en_A = ~a_valid | en_B
  - in_ready = en_A (combinational)
  - Latency is 2 cycles from accept to out_valid when unstalled; throughput is 1/cycle.
  - While out_valid=1 and out_ready=0, out_inst, out_err and out_addr hold stable.
- Address:
  - out_addr increments by 1 after each out_valid&out_ready, wrapping to 0 after 2^ADDR_W-1.
  - clr sets out_addr=0. clr wins over a simultaneous increment.
- Packing:
  - R (EXT_NONE): funct7, rs2, rs1, f3, rd, op. Never errs.
  - I: imm[11:0], rs1, f3, rd, op. err if imm ∉ [-2048, 2047].
  - I-shift (fmt I and funct3 ∈ {001, 101}): funct7, imm[4:0], rs1, f3, rd, op. err if imm ∉ [0, 31].
  - S: imm[11:5], rs2, rs1, f3, imm[4:0], op. err if imm ∉ [-2048, 2047].
  - B: imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op. err if imm odd or ∉ [-4096, 4094].
  - U: imm[31:12], rd, op. err if imm[11:0] ≠ 0.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, op. err if imm odd or ∉ [-2^20, 2^20-2].
  - fmt codes not defined in defines.vh: err.
- On err:
  - out_inst = 32'h0000_0013 (NOP) and out_err=1.
  - The word is still emitted and consumes an address.
  - err_sticky sets when that word handshakes.

Decomposition:
- `EXT_*` format codes come from defines.vh.
- Add to defines.vh: `INST_NOP` (32'h0000_0013) and the two shift funct3 codes.
- One sub-module, imm_pack: purely combinational pack + range check (fmt, fields, imm → inst, err), instantiated in stage A. The top module holds the pipeline, handshake and counter.

Test Plan:
- addi x1,x0,5 (I, op 0010011, f3 000, rd 1, rs1 0, imm 5) → out_inst 0x00500093, err 0, out_addr 0, two cycles after accept.
- Back-to-back, out_ready=1:
  - sw x2,8(x1) → 0x0020A423
  - beq x0,x0,-4 → 0xFE000EE3
  - lui x5, imm 0x12345000 → 0x123452B7
  - jal x1, imm 2048 → 0x001000EF
  - srai x3,x3,4 (funct7 0100000) → 0x4041D193
  - out_addr 0..4 in order.
- B with imm 3; I with imm 2048; U with imm 0x1001 → each out_inst 0x00000013, out_err 1, err_sticky 1 after the first; clr → err_sticky 0 and out_addr 0.
- out_ready=0 with continuous in_valid → exactly 2 words accepted, then in_ready=0 and outputs stable. Raise out_ready → all words drain in order, no loss or duplication.
- ADDR_W=2, 5 words → out_addr 0,1,2,3,0.
- rst_n low asynchronously with both stages full → out_valid and out_addr go to 0 immediately; no stale word after release.
